// File: rtl/mc_config_loader.sv
// mc_config_loader: serial macrocell configuration loader with shadow register and optional even parity
module mc_config_loader #(
  parameter int PARITY_EN = 1
) (
  input  logic       clk_v,
  input  logic       rst_v,
  input  logic       cfg_start_v,
  input  logic       cfg_bit_v,
  input  logic       cfg_valid_v,
  output logic       cfg_ready_v,
  output logic       cfg_done_v,
  output logic       cfg_err_v,
  output logic       pt1_mux,
  output logic       pt2_mux,
  output logic       pt3_mux,
  output logic       pt4_mux,
  output logic       pt5_mux,
  output logic       gclr_mux,
  output logic       pt4_func_mux,
  output logic       pt5_func_mux,
  output logic       xor_a_mux,
  output logic       xor_b_mux,
  output logic       xor_inv_mux,
  output logic       d_mux,
  output logic       storage_mux,
  output logic       fb_mux,
  output logic       o_mux,
  output logic [0:2] oe_mux,
  output logic [0:1] gclk_mux
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, ERROR} state_t;
  localparam logic [4:0] LAST = (PARITY_EN != 0) ? 5'd20 : 5'd19;
  state_t      state;
  logic [4:0]  cnt;
  logic [19:0] shadow, sh_nx, cfg_q;
  logic        par_err;
  // bits shift in from the top so frame bit 0 lands in shadow[0] after 20 bits
  assign sh_nx   = (cnt < 5'd20) ? {cfg_bit_v, shadow[19:1]} : shadow;
  assign par_err = (PARITY_EN != 0) && (^shadow ^ cfg_bit_v);
  always_ff @(posedge clk_v) begin
    if (rst_v) begin
      state  <= IDLE;
      cnt    <= '0;
      shadow <= '0;
      cfg_q  <= '0;
    end else if (cfg_start_v) begin
      state  <= SHIFT;
      cnt    <= '0;
      shadow <= '0;
    end else begin
      case (state)
        SHIFT: if (cfg_valid_v) begin
          shadow <= sh_nx;
          cnt    <= cnt + 5'd1;
          if (cnt == LAST) begin
            state <= par_err ? ERROR : DONE;
            if (!par_err) cfg_q <= sh_nx;
          end
        end
        DONE: state <= IDLE;
        default: ;
      endcase
    end
  end
  assign cfg_ready_v  = state == SHIFT;
  assign cfg_done_v   = state == DONE;
  assign cfg_err_v    = state == ERROR;
  assign pt1_mux      = cfg_q[0];
  assign pt2_mux      = cfg_q[1];
  assign pt3_mux      = cfg_q[2];
  assign pt4_mux      = cfg_q[3];
  assign pt5_mux      = cfg_q[4];
  assign gclr_mux     = cfg_q[5];
  assign pt4_func_mux = cfg_q[6];
  assign pt5_func_mux = cfg_q[7];
  assign xor_a_mux    = cfg_q[8];
  assign xor_b_mux    = cfg_q[9];
  assign xor_inv_mux  = cfg_q[10];
  assign d_mux        = cfg_q[11];
  assign storage_mux  = cfg_q[12];
  assign fb_mux       = cfg_q[13];
  assign o_mux        = cfg_q[14];
  assign oe_mux       = {cfg_q[15], cfg_q[16], cfg_q[17]};
  assign gclk_mux     = {cfg_q[18], cfg_q[19]};
endmodule

// File: doc/mc_config_loader.md
MC_CONFIG_LOADER -- requirements
Module: mc_config_loader

Interface
REQ-001 Parameter PARITY_EN, default 1: 1 = frame carries a trailing even-parity bit that is checked; 0 = no parity bit, frame is 20 bits.
REQ-002 clk_v  input  1  sole clock, rising-edge.
REQ-003 rst_v  input  1  synchronous reset, active-high, sampled on rising clk_v.
REQ-004 cfg_start_v  input  1  begins a new frame; aborts any frame in progress.
REQ-005 cfg_bit_v  input  1  serial configuration data bit.
REQ-006 cfg_valid_v  input  1  cfg_bit_v is valid this cycle.
REQ-007 cfg_ready_v  output  1  loader accepts a bit this cycle.
REQ-008 cfg_done_v  output  1  one-cycle pulse: frame committed.
REQ-009 cfg_err_v  output  1  parity failure; held until cleared.
REQ-010 pt1_mux, pt2_mux, pt3_mux, pt4_mux, pt5_mux, gclr_mux, pt4_func_mux, pt5_func_mux, xor_a_mux, xor_b_mux, xor_inv_mux, d_mux, storage_mux, fb_mux, o_mux  output  1 each  committed macrocell config bits, driven straight into the macrocell core.
REQ-011 oe_mux  output  [0:2]  committed output-enable select.
REQ-012 gclk_mux  output  [0:1]  committed global-clock select.

Function
REQ-013 FSM states are IDLE, SHIFT, DONE and ERROR, and every transition occurs on the rising edge of clk_v.
REQ-014 A bit is accepted on any edge where cfg_valid_v=1 and cfg_ready_v=1; cfg_ready_v=1 only in SHIFT, and a cfg_valid_v that is not accepted is ignored without error.
REQ-015 Frame order, first accepted bit first: 0 pt1, 1 pt2, 2 pt3, 3 pt4, 4 pt5, 5 gclr, 6 pt4_func, 7 pt5_func, 8 xor_a, 9 xor_b, 10 xor_inv, 11 d, 12 storage, 13 fb, 14 o, 15..17 oe_mux[0..2], 18..19 gclk_mux[0..1], 20 parity (only when PARITY_EN=1).
REQ-016 Incoming bits go into a 20-bit shadow register and a bit counter (0..20); the committed outputs do not change while a frame is being shifted.
REQ-017 Transitions from IDLE: cfg_start_v=1 -> SHIFT with the counter cleared; a cfg_bit_v presented in that same cycle is not accepted.
REQ-018 Transitions within SHIFT: cfg_start_v=1 -> stay in SHIFT, clear the counter, discard the shadow contents and accept no bit that cycle (start has priority over valid).
REQ-019 On the edge that accepts the last frame bit (bit 19 when PARITY_EN=0, bit 20 when PARITY_EN=1), the checks below are applied.
REQ-020 If PARITY_EN=0, or the XOR of all 21 bits is 0: commit shadow -> outputs on that edge and go to DONE.
REQ-021 If PARITY_EN=1 and the XOR of all 21 bits is 1: leave the outputs unchanged and go to ERROR.
REQ-022 cfg_done_v=1 exactly while in DONE, and DONE lasts one cycle before returning to IDLE; cfg_start_v in DONE -> SHIFT.
REQ-023 ERROR is held with cfg_err_v=1; cfg_start_v -> SHIFT and clears cfg_err_v on the same edge.
REQ-024 Latency: the committed outputs and cfg_done_v first show the new values in the cycle after the last bit is accepted.
REQ-025 Committed outputs change only on a commit or a reset; cfg_start_v, an abort or an error never alter them.
REQ-026 cfg_valid_v in IDLE, DONE or ERROR is ignored and has no effect on the FSM or the counter.

Reset
REQ-027 rst_v=1 -> state IDLE, counter 0, shadow 0, every committed output 0 (oe_mux=3'b000, gclk_mux=2'b00), cfg_ready_v=0, cfg_done_v=0, cfg_err_v=0.
REQ-028 Reset has priority over cfg_start_v and cfg_valid_v in any state; a reset in mid-frame discards the frame and commits nothing.

Verification
REQ-029 Reset, then start, then 21 consecutive valid bits with bits 0..19 = 1 and parity = 0 (PARITY_EN=1) -> cfg_done_v pulses for 1 cycle, every 1-bit mux = 1, oe_mux=3'b111, gclk_mux=2'b11, cfg_err_v=0.
REQ-030 Same frame but parity = 1 -> cfg_err_v=1, outputs stay at the previous committed values, cfg_done_v stays 0; a following start clears cfg_err_v.
REQ-031 Start, 10 valid bits, then start again, then a full good frame with only bit 14 = 1 and parity 1 -> only o_mux=1; the first 10 bits have no effect.
REQ-032 Good frame with cfg_valid_v toggling 1,0,1,0 throughout -> same result as contiguous delivery; cfg_done_v arrives the cycle after the 21st accepted bit.
REQ-033 rst_v asserted at bit 12 of a frame whose outputs were all-1 before -> all outputs 0, state IDLE, cfg_ready_v=0 on the next cycle.
REQ-034 PARITY_EN=0, 20-bit frame with bits 15..17 = 1,0,1 and all other bits 0 -> oe_mux=3'b101, cfg_done_v pulses the cycle after bit 19 is accepted.
